// File: rtl/trg_frame_packer.sv
// Trigger frame packer: wraps each accepted trigger window of delayed ADC words
// in a header/footer pair and queues the frame in a first-word-fall-through FIFO.
module trg_frame_packer #(
  parameter int TIME_STAMP_WIDTH   = 16,
  parameter int S_AXIS_TDATA_WIDTH = 128,
  parameter int PRE_ACQUI_LEN      = 8,
  parameter int MAX_DATA_WORDS     = 100,
  parameter int FIFO_DEPTH         = 512
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          TRIGGERD_FLAG,
  input  logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
  output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic [15:0]                   DROP_COUNT
);

  localparam int DW = S_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // A frame is at most MAX_DATA_WORDS data words plus header and footer.
  localparam logic [CW-1:0] ADMIT_LIMIT = CW'(FIFO_DEPTH - MAX_DATA_WORDS - 2);
  localparam logic [15:0]   MAX_WORDS   = 16'(MAX_DATA_WORDS);
  localparam logic [15:0]   TAIL_LEN    = 16'(PRE_ACQUI_LEN);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    TAIL,
    FOOTER,
    WAIT_LOW
  } state_t;

  state_t          state;
  logic [DW-1:0]   dly [PRE_ACQUI_LEN+1];
  logic            flag_q;
  logic            rise;
  logic            admit;
  logic [15:0]     seq_num;
  logic [15:0]     word_cnt;
  logic [15:0]     word_cnt_inc;
  logic [15:0]     tail_cnt;
  logic            truncated;

  logic [DW-1:0]   header;
  logic [DW-1:0]   footer;
  logic            push;
  logic [DW:0]     push_word;
  logic            pop;

  logic [DW:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;

  // The word leaving dly[PRE_ACQUI_LEN] was sampled PRE_ACQUI_LEN+1 edges ago.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      for (int i = 0; i <= PRE_ACQUI_LEN; i++) dly[i] <= '0;
      flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage capture the previous
      // stage's old value, so the chain shifts by exactly one per edge.
      dly[0] <= S_AXIS_TDATA;
      for (int i = 1; i <= PRE_ACQUI_LEN; i++) dly[i] <= dly[i-1];
      flag_q <= TRIGGERD_FLAG;
    end
  end

  assign rise         = TRIGGERD_FLAG & ~flag_q;
  assign admit        = (state == IDLE) && rise && (fifo_cnt <= ADMIT_LIMIT);
  assign word_cnt_inc = word_cnt + 16'd1;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state      <= IDLE;
      seq_num    <= '0;
      word_cnt   <= '0;
      tail_cnt   <= '0;
      truncated  <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      if (rise && !admit && (DROP_COUNT != 16'hFFFF))
        DROP_COUNT <= DROP_COUNT + 16'd1;

      unique case (state)
        IDLE: begin
          if (admit) begin
            state     <= DATA;
            word_cnt  <= '0;
            tail_cnt  <= '0;
            truncated <= 1'b0;
          end
        end
        DATA: begin
          word_cnt <= word_cnt_inc;
          if (word_cnt_inc == MAX_WORDS) begin
            truncated <= 1'b1;
            state     <= FOOTER;
          end else if (!TRIGGERD_FLAG) begin
            state <= TAIL;
          end
        end
        TAIL: begin
          word_cnt <= word_cnt_inc;
          tail_cnt <= tail_cnt + 16'd1;
          if (word_cnt_inc == MAX_WORDS) begin
            truncated <= 1'b1;
            state     <= FOOTER;
          end else if (tail_cnt + 16'd1 == TAIL_LEN) begin
            state <= FOOTER;
          end
        end
        FOOTER: begin
          seq_num <= seq_num + 16'd1;
          state   <= (truncated && TRIGGERD_FLAG) ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          if (!TRIGGERD_FLAG) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    header                        = '0;
    header[127:112]               = 16'hAA55;
    header[111:96]                = seq_num;
    header[TIME_STAMP_WIDTH-1:0]  = TIME_STAMP;
    footer                        = '0;
    footer[127:112]               = 16'h55AA;
    footer[111:96]                = word_cnt;
    footer[0]                     = truncated;
  end

  // The header is written in the rise cycle itself, before the state changes.
  always_comb begin
    // NOTE: defaulting every output of the block first keeps states that
    // write nothing from inferring latches.
    push      = 1'b0;
    push_word = '0;
    unique case (state)
      IDLE: begin
        if (admit) begin
          push      = 1'b1;
          push_word = {1'b0, header};
        end
      end
      DATA, TAIL: begin
        push      = 1'b1;
        push_word = {1'b0, dly[PRE_ACQUI_LEN]};
      end
      FOOTER: begin
        push      = 1'b1;
        push_word = {1'b1, footer};
      end
      default: ;
    endcase
  end

  assign pop = M_AXIS_TVALID & M_AXIS_TREADY;

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and fill level, which keeps the array mappable onto RAM.
  always_ff @(posedge AXIS_ACLK) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Head entry is shown directly; gating with TVALID gives zeros when empty.
  assign M_AXIS_TVALID                = (fifo_cnt != '0);
  assign {M_AXIS_TLAST, M_AXIS_TDATA} = M_AXIS_TVALID ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_trg_frame_packer.sv
// Self-checking bench for trg_frame_packer: frame-level reference model with
// randomized stimulus, plus literal expectations for the directed scenarios.
module tb_trg_frame_packer;

  localparam int TSW   = 16;
  localparam int DW    = 128;
  localparam int P     = 8;
  localparam int MAXW  = 100;
  localparam int DEPTH = 512;

  typedef logic [DW:0] word_t;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic [DW-1:0]   sdata = '0;
  logic            flag  = 1'b0;
  logic [TSW-1:0]  ts    = '0;
  logic            ready = 1'b0;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tlast;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  trg_frame_packer #(
    .TIME_STAMP_WIDTH  (TSW),
    .S_AXIS_TDATA_WIDTH(DW),
    .PRE_ACQUI_LEN     (P),
    .MAX_DATA_WORDS    (MAXW),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .S_AXIS_TDATA (sdata),
    .TRIGGERD_FLAG(flag),
    .TIME_STAMP   (ts),
    .M_AXIS_TDATA (tdata),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(ready),
    .M_AXIS_TLAST (tlast),
    .DROP_COUNT   (drop_count)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t hdr(input logic [15:0] seq, input logic [TSW-1:0] t_s);
    return {1'b0, 16'hAA55, seq, 80'd0, t_s};
  endfunction

  function automatic word_t ftr(input logic [15:0] n, input logic tr);
    return {1'b1, 16'h55AA, n, 95'd0, tr};
  endfunction

  // Reference model: expected FIFO contents in order, fill level and drops.
  word_t          exp_q[$];
  word_t          out_log[$];
  logic [DW-1:0]  samp_q[$];
  int             mfill;
  int             mdrop;
  logic [15:0]    mseq;
  bit             prev_f;
  bit             in_frame;
  bit             waiting_low;
  int             t0;
  int             hi_len;
  int             emitted;
  int             cyc = 0;

  function automatic void model_reset();
    exp_q.delete();
    samp_q.delete();
    for (int i = 0; i <= P; i++) samp_q.push_back('0);
    mfill = 0; mdrop = 0; mseq = '0; prev_f = 0;
    in_frame = 0; waiting_low = 0; hi_len = -1; emitted = 0;
  endfunction

  function automatic void note_drop();
    if (mdrop < 65535) mdrop++;
  endfunction

  function automatic void model_step(input logic f, input logic [DW-1:0] x,
                                     input logic [TSW-1:0] t_s, input logic r);
    word_t         w;
    bit            push;
    bit            pop;
    bit            rise;
    logic [DW-1:0] delayed;
    int            target;
    w = '0;
    push = 0;
    delayed = samp_q.pop_front();
    samp_q.push_back(x);
    rise = f && !prev_f;
    pop  = (mfill > 0) && r;
    if (in_frame) begin
      if (rise) note_drop();
      if (hi_len < 0 && !f) hi_len = cyc - t0;
      target = (hi_len < 0) ? MAXW : ((hi_len + P < MAXW) ? hi_len + P : MAXW);
      push = 1;
      if (emitted < target) begin
        w = {1'b0, delayed};
        emitted++;
      end else begin
        w = ftr(16'(emitted), emitted == MAXW);
        mseq++;
        in_frame = 0;
        waiting_low = (emitted == MAXW) && f;
      end
    end else if (waiting_low) begin
      if (rise) note_drop();
      if (!f) waiting_low = 0;
    end else if (rise) begin
      if (DEPTH - mfill >= MAXW + 2) begin
        push = 1;
        w = hdr(mseq, t_s);
        in_frame = 1;
        t0 = cyc;
        hi_len = -1;
        emitted = 0;
      end else begin
        note_drop();
      end
    end
    if (push) exp_q.push_back(w);
    mfill = mfill + int'(push) - int'(pop);
    prev_f = f;
  endfunction

  // Compare process: outputs sampled mid-cycle, then the model advances.
  bit    stall_prev = 0;
  word_t held;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      stall_prev = 0;
      check("reset_tvalid", 160'(tvalid), 160'(0));
      check("reset_tlast_tdata", 160'({tlast, tdata}), 160'(0));
      check("reset_drop", 160'(drop_count), 160'(0));
    end else begin
      check("tvalid", 160'(tvalid), 160'(mfill > 0));
      if (stall_prev) check("stall_stable", 160'({tlast, tdata}), 160'(held));
      if (mfill > 0 && ready) begin
        if (exp_q.size() == 0) check("word_unexpected", 160'({tlast, tdata}), 160'(0));
        else check("word", 160'({tlast, tdata}), 160'(exp_q.pop_front()));
        out_log.push_back({tlast, tdata});
      end
      check("drop_count", 160'(drop_count), 160'(mdrop));
      stall_prev = tvalid && !ready;
      held = {tlast, tdata};
      model_step(flag, sdata, ts, ready);
      cyc++;
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  longint         ctr = 0;
  longint         c_r;
  logic [TSW-1:0] ts_val = 16'h1234;

  task automatic tick(input logic f, input logic r);
    @(posedge clk); #1;
    flag = f; ready = r; sdata = DW'(ctr); ts = ts_val;
    ctr++;
  endtask

  task automatic rtick(input logic f);
    @(posedge clk); #1;
    flag  = f;
    ready = ($urandom_range(0, 3) != 0);
    sdata = {$urandom, $urandom, $urandom, $urandom};
    ts    = TSW'($urandom);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) tick(1'b0, r);
  endtask

  task automatic pulse(input int n, input logic r);
    repeat (n) tick(1'b1, r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flag = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick(1'b0, 1'b1);
      done = !tvalid && !in_frame && !waiting_low;
    end
    check("drain_timeout", 160'(done), 160'(1));
  endtask

  initial begin
    int tl;

    // Short trigger window, always-ready sink.
    do_reset();
    idle(12, 1'b1);
    out_log.delete();
    c_r = ctr;
    pulse(5, 1'b1);
    wait_drain();
    check("short_len", 160'(out_log.size()), 160'(15));
    check("short_header", 160'(out_log[0]), 160'(hdr(16'd0, 16'h1234)));
    check("short_first_data", 160'(out_log[1]), 160'({1'b0, DW'(c_r - 8)}));
    check("short_last_data", 160'(out_log[13]), 160'({1'b0, DW'(c_r + 4)}));
    check("short_footer", 160'(out_log[14]), 160'(ftr(16'd13, 1'b0)));
    tl = 0;
    foreach (out_log[i]) tl += int'(out_log[i][DW]);
    check("short_tlast_count", 160'(tl), 160'(1));

    // Long window: truncation, then the next frame.
    do_reset();
    idle(12, 1'b1);
    out_log.delete();
    pulse(150, 1'b1);
    wait_drain();
    check("long_len", 160'(out_log.size()), 160'(102));
    check("long_header", 160'(out_log[0]), 160'(hdr(16'd0, 16'h1234)));
    check("long_footer", 160'(out_log[101]), 160'(ftr(16'd100, 1'b1)));
    out_log.delete();
    pulse(3, 1'b1);
    wait_drain();
    check("after_long_header", 160'(out_log[0]), 160'(hdr(16'd1, 16'h1234)));
    check("after_long_footer", 160'(out_log[out_log.size()-1]), 160'(ftr(16'd11, 1'b0)));

    // Stalled sink: fill until admission fails.
    do_reset();
    idle(12, 1'b0);
    for (int k = 0; k < 30 && mfill <= 410; k++) begin
      pulse(20, 1'b0);
      idle(12, 1'b0);
    end
    pulse(20, 1'b0);
    idle(12, 1'b0);
    check("full_drop", 160'(drop_count), 160'(1));
    wait_drain();
    out_log.delete();
    pulse(5, 1'b1);
    wait_drain();
    check("full_next_header", 160'(out_log[0]), 160'(hdr(16'd14, 16'h1234)));

    // Second rise while the tail is still being written.
    do_reset();
    idle(12, 1'b1);
    out_log.delete();
    pulse(5, 1'b1);
    idle(3, 1'b1);
    pulse(4, 1'b1);
    wait_drain();
    check("tail_rise_drop", 160'(drop_count), 160'(1));
    check("tail_rise_len", 160'(out_log.size()), 160'(15));
    check("tail_rise_footer", 160'(out_log[14]), 160'(ftr(16'd13, 1'b0)));

    // Random windows, gaps, data, time stamps and sink backpressure.
    do_reset();
    idle(12, 1'b1);
    for (int e = 0; e < 14; e++) begin
      int hl;
      int gl;
      hl = $urandom_range(1, 130);
      gl = $urandom_range(1, 40);
      repeat (hl) rtick(1'b1);
      repeat (gl) rtick(1'b0);
    end
    wait_drain();

    // Reset asserted in the middle of a frame.
    do_reset();
    idle(12, 1'b0);
    pulse(5, 1'b0);
    idle(3, 1'b0);
    pulse(4, 1'b0);
    idle(20, 1'b0);
    pulse(6, 1'b0);
    check("pre_reset_drop", 160'(drop_count), 160'(1));
    check("pre_reset_tvalid", 160'(tvalid), 160'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset_tvalid", 160'(tvalid), 160'(0));
    check("async_reset_drop", 160'(drop_count), 160'(0));
    check("async_reset_tdata", 160'({tlast, tdata}), 160'(0));
    flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(12, 1'b1);
    out_log.delete();
    pulse(5, 1'b1);
    wait_drain();
    check("post_reset_header", 160'(out_log[0]), 160'(hdr(16'd0, 16'h1234)));
    check("post_reset_len", 160'(out_log.size()), 160'(15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
